// File: rtl/rob_pkg.sv
// Shared ROB types: entry layout {ready, rd, value}, commit FSM states and default widths.
// Used by the ROB FIFO, issue, rename and commit logic alike.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

package rob_pkg;

    localparam int unsigned DEF_XLEN   = `XLEN;
    localparam int unsigned DEF_REG_AW = `REG_ADDR_WIDTH;
    localparam int unsigned ROB_AW     = 3;

    typedef struct packed {
        logic                  ready;
        logic [DEF_REG_AW-1:0] rd;
        logic [DEF_XLEN-1:0]   value;
    } rob_entry_t;

    typedef enum logic [1:0] {
        StRun,
        StFlush,
        StDone
    } commit_state_t;

endpackage

// File: rtl/rob_commit_if.sv
// Commit-stage bus: ROB head read/pop, register-file and rename-table writes, flush
// handshake and performance counters. master = commit engine, slave = its surroundings.
interface rob_commit_if #(
    parameter int unsigned XLEN    = rob_pkg::DEF_XLEN,
    parameter int unsigned REG_AW  = rob_pkg::DEF_REG_AW,
    parameter int unsigned ROB_AW  = rob_pkg::ROB_AW,
    parameter int unsigned ENTRY_W = 1 + REG_AW + XLEN
);
    logic               rob_empty_i;
    logic [ENTRY_W-1:0] rob_head_i;
    logic               rob_head_en_o;
    logic [ROB_AW-1:0]  head_tag_o;
    logic               rf_wr_en_o;
    logic [REG_AW-1:0]  rf_wr_addr_o;
    logic [XLEN-1:0]    rf_wr_data_o;
    logic               rat_clr_en_o;
    logic [ROB_AW-1:0]  rat_clr_tag_o;
    logic               flush_i;
    logic               flush_done_o;
    logic [31:0]        retire_cnt_o;
    logic [31:0]        stall_cnt_o;

    modport master (
        input  rob_empty_i, rob_head_i, flush_i,
        output rob_head_en_o, head_tag_o, rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o,
               rat_clr_en_o, rat_clr_tag_o, flush_done_o, retire_cnt_o, stall_cnt_o
    );

    modport slave (
        output rob_empty_i, rob_head_i, flush_i,
        input  rob_head_en_o, head_tag_o, rf_wr_en_o, rf_wr_addr_o, rf_wr_data_o,
               rat_clr_en_o, rat_clr_tag_o, flush_done_o, retire_cnt_o, stall_cnt_o
    );

endinterface

// File: rtl/commit_perf_cnt.sv
// Retire and stall counters for the commit stage (32-bit, wrapping).
// Only built when COMMIT_PERF_CNT_EN is defined; otherwise this file is empty.
`ifdef COMMIT_PERF_CNT_EN
module commit_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_retire,
    input  logic        i_stall,
    output logic [31:0] o_retire_cnt,
    output logic [31:0] o_stall_cnt
);
    logic [31:0] r_retire_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retire_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (i_retire) r_retire_cnt <= r_retire_cnt + 32'd1;
            if (i_stall)  r_stall_cnt  <= r_stall_cnt + 32'd1;
        end
    end

    assign o_retire_cnt = r_retire_cnt;
    assign o_stall_cnt  = r_stall_cnt;
endmodule
`endif

// File: rtl/rob_commit.sv
// In-order ROB retirement: pops a ready head, registers the rf/rat write, drains on flush.
// Optional perf counters are enabled with COMMIT_PERF_CNT_EN.
module rob_commit #(
    parameter int unsigned XLEN    = rob_pkg::DEF_XLEN,
    parameter int unsigned REG_AW  = rob_pkg::DEF_REG_AW,
    parameter int unsigned ROB_AW  = rob_pkg::ROB_AW,
    parameter int unsigned ENTRY_W = 1 + REG_AW + XLEN
) (
    input logic          clk,
    input logic          rst,
    rob_commit_if.master bus
);
    import rob_pkg::*;

    commit_state_t     r_state;
    commit_state_t     w_state_nxt;
    logic              w_head_ready;
    logic [REG_AW-1:0] w_head_rd;
    logic [XLEN-1:0]   w_head_value;
    logic              w_pop;
    logic              w_commit;
    logic              w_flush_done;

    logic [ROB_AW-1:0] r_head_tag;
    logic              r_rf_wr_en;
    logic [REG_AW-1:0] r_rf_wr_addr;
    logic [XLEN-1:0]   r_rf_wr_data;
    logic              r_rat_clr_en;
    logic [ROB_AW-1:0] r_rat_clr_tag;

    assign w_head_ready = bus.rob_head_i[ENTRY_W-1];
    assign w_head_rd    = bus.rob_head_i[XLEN +: REG_AW];
    assign w_head_value = bus.rob_head_i[XLEN-1:0];

    // A flush request in RUN wins over a ready head: nothing retires in that cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_commit     = 1'b0;
        w_flush_done = 1'b0;
        unique case (r_state)
            StRun: begin
                if (bus.flush_i) begin
                    w_state_nxt = StFlush;
                end else begin
                    w_commit = !bus.rob_empty_i && w_head_ready;
                    w_pop    = w_commit;
                end
            end
            StFlush: begin
                w_pop = !bus.rob_empty_i;
                if (bus.rob_empty_i) w_state_nxt = StDone;
            end
            StDone: begin
                w_flush_done = 1'b1;
                w_state_nxt  = StRun;
            end
            default: w_state_nxt = StRun;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StRun;
            r_head_tag    <= '0;
            r_rf_wr_en    <= 1'b0;
            r_rf_wr_addr  <= '0;
            r_rf_wr_data  <= '0;
            r_rat_clr_en  <= 1'b0;
            r_rat_clr_tag <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rf_wr_en   <= w_commit && (w_head_rd != '0);
            r_rat_clr_en <= w_commit;
            if (w_pop) r_head_tag <= r_head_tag + ROB_AW'(1);
            if (w_commit) begin
                r_rf_wr_addr  <= w_head_rd;
                r_rf_wr_data  <= w_head_value;
                r_rat_clr_tag <= r_head_tag;
            end
        end
    end

    assign bus.rob_head_en_o = w_pop;
    assign bus.head_tag_o    = r_head_tag;
    assign bus.rf_wr_en_o    = r_rf_wr_en;
    assign bus.rf_wr_addr_o  = r_rf_wr_addr;
    assign bus.rf_wr_data_o  = r_rf_wr_data;
    assign bus.rat_clr_en_o  = r_rat_clr_en;
    assign bus.rat_clr_tag_o = r_rat_clr_tag;
    assign bus.flush_done_o  = w_flush_done;

`ifdef COMMIT_PERF_CNT_EN
    logic w_stall;
    assign w_stall = (r_state == StRun) && !bus.rob_empty_i && !w_head_ready;

    commit_perf_cnt u_perf (
        .clk          (clk),
        .rst          (rst),
        .i_retire     (w_commit),
        .i_stall      (w_stall),
        .o_retire_cnt (bus.retire_cnt_o),
        .o_stall_cnt  (bus.stall_cnt_o)
    );
`else
    assign bus.retire_cnt_o = '0;
    assign bus.stall_cnt_o  = '0;
`endif

endmodule
